// File: rtl/ua_pkg.sv
// ua_pkg: UART state encoding and counter sizing helper.
// Shared by ua_receive and the transmitter.
package ua_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } ua_state_e;

    localparam int UaDataBits = 8;

    // Smallest width able to hold value-1, never below one bit.
    function automatic int ua_log2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ua_sync.sv
// ua_sync: two-flop synchronizer for an asynchronous input.
// Both flops reset to ResetValue so the line reads idle after reset.
module ua_sync #(
    parameter logic ResetValue = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic D_i,
    output logic Q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= D_i;
            sync_q <= meta_q;
        end
    end

    assign Q_o = sync_q;

endmodule

// File: rtl/ua_receive.sv
// ua_receive: 8N1 UART receiver with a valid/ready byte output.
// Define UA_RECEIVE_FRAMING_ERR_EN to drop bad-stop bytes and pulse FramingError.
module ua_receive #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
`ifdef UA_RECEIVE_FRAMING_ERR_EN
    output logic       FramingError,
`endif
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady
);

    import ua_pkg::*;

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int SampleTime     = SymbolEdgeTime / 2;
    localparam int CntW           = ua_log2(SymbolEdgeTime);

    localparam logic [CntW-1:0] EdgeLast   = CntW'(SymbolEdgeTime - 1);
    localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    logic                  sin_sync;
    logic                  sin_prev_q;

    ua_state_e             state_q;
    ua_state_e             state_d;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    logic [2:0]            bit_q;
    logic [2:0]            bit_d;
    logic [UaDataBits-1:0] shift_q;
    logic [UaDataBits-1:0] shift_d;
    logic [UaDataBits-1:0] dout_q;
    logic [UaDataBits-1:0] dout_d;
    logic                  valid_q;
    logic                  valid_d;

    logic                  done;
    logic                  stop_ok;
    logic                  deliver;

`ifdef UA_RECEIVE_FRAMING_ERR_EN
    logic                  fe_q;
    logic                  fe_d;
`endif

    ua_sync #(
        .ResetValue(1'b1)
    ) u_sync (
        .Clock(Clock),
        .Reset(Reset),
        .D_i  (SIn),
        .Q_o  (sin_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntOne;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        stop_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sin_prev_q && !sin_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == SampleLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sin_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == EdgeLast) begin
                    cnt_d   = '0;
                    shift_d = {sin_sync, shift_q[UaDataBits-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == EdgeLast) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    stop_ok = sin_sync;
                    state_d = sin_sync ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (sin_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A finished byte is only taken when the output slot is free or
    // being drained this cycle; otherwise it is an overrun and dropped.
    always_comb begin
`ifdef UA_RECEIVE_FRAMING_ERR_EN
        deliver = done && stop_ok;
        fe_d    = done && !stop_ok;
`else
        deliver = done;
`endif
        dout_d  = dout_q;
        valid_d = valid_q;
        if (valid_q && DataOutReady) begin
            valid_d = 1'b0;
        end
        if (deliver && (!valid_q || DataOutReady)) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            sin_prev_q <= 1'b1;
`ifdef UA_RECEIVE_FRAMING_ERR_EN
            fe_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            sin_prev_q <= sin_sync;
`ifdef UA_RECEIVE_FRAMING_ERR_EN
            fe_q       <= fe_d;
`endif
        end
    end

    assign DataOut      = dout_q;
    assign DataOutValid = valid_q;
`ifdef UA_RECEIVE_FRAMING_ERR_EN
    assign FramingError = fe_q;
`endif

endmodule
